// File: rtl/lamp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_ctrl_pkg
//  Purpose  : Shared definitions for the staircase-lamp timer controller.
//             Holds the lamp state encoding reported on lamp_state.
//  Contents : lamp_state_t  IDLE = 2'b00, ON = 2'b01, WARN = 2'b10
//  Revision : 1.0  initial release
// ============================================================================
package lamp_ctrl_pkg;

    // Encoding is externally visible on lamp_state, so it is pinned explicitly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        WARN = 2'b10
    } lamp_state_t;

endpackage : lamp_ctrl_pkg
`default_nettype wire

// File: rtl/lamp_sw_edge.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_sw_edge
//  Purpose  : Per-bit two-flop synchronizer followed by a rising-edge detector
//             for the raw wall-switch levels.
//  Ports    : clk      in   system clock, rising edge
//             rst      in   asynchronous reset, active-high
//             s        in   [N_SW] raw switch levels (asynchronous to clk)
//             sw_edge  out  [N_SW] one-cycle pulse per synchronized rising edge
//  Revision : 1.0  initial release
// ============================================================================
module lamp_sw_edge
    import lamp_ctrl_pkg::*;
#(
    parameter int N_SW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] s,
    output logic [N_SW-1:0] sw_edge
);

    logic [N_SW-1:0] r_sync1;
    logic [N_SW-1:0] r_sync2;
    logic [N_SW-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= s;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // r_prev clears in reset, so a switch already high when reset is released
    // produces exactly one edge once it has crossed the synchronizer.
    assign sw_edge = r_sync2 & ~r_prev;

endmodule : lamp_sw_edge
`default_nettype wire

// File: rtl/lamp_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_timer_ctrl
//  Purpose  : Timed staircase-lamp controller. A rising edge on any wall
//             switch lights the lamp and (re)starts a shared on-timer. The
//             last WARN_CYCLES of the lit period are a warning phase, after
//             which the lamp turns off by itself.
//  Ports    : clk         in   system clock, rising edge
//             rst         in   asynchronous reset, active-high
//             S           in   [N_SW] raw switch levels (asynchronous)
//             F           out  lamp drive
//             lamp_state  out  [2] 00 IDLE, 01 ON, 10 WARN
//             remaining   out  [$clog2(ON_CYCLES)] current timer value
//             sw_edge     out  [N_SW] per-switch rising-edge pulse (debug)
//  Config   : LAMP_WARN_BLINK_EN  defined   -> F blinks during WARN
//                                 undefined -> F held high during WARN, no
//                                              blink counter built
//  Revision : 1.0  initial release
// ============================================================================
module lamp_timer_ctrl #(
    parameter int N_SW        = 3,
    parameter int ON_CYCLES   = 300,
    parameter int WARN_CYCLES = 50,
    parameter int BLINK_HALF  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SW-1:0]              S,
    output logic                         F,
    output logic [1:0]                   lamp_state,
    output logic [$clog2(ON_CYCLES)-1:0] remaining,
    output logic [N_SW-1:0]              sw_edge
);

    import lamp_ctrl_pkg::*;

    localparam int W = $clog2(ON_CYCLES);

    localparam logic [W-1:0] c_RELOAD  = W'(ON_CYCLES - 1);
    localparam logic [W-1:0] c_WARN_AT = W'(WARN_CYCLES);

    lamp_state_t     r_state;
    logic [W-1:0]    r_timer;
    logic            r_f;

    logic [N_SW-1:0] w_sw_edge;
    logic            w_trig;
    logic            w_warn_f;   // lamp level for the next WARN cycle

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    lamp_sw_edge #(
        .N_SW    (N_SW)
    ) u_sw_edge (
        .clk     (clk),
        .rst     (rst),
        .s       (S),
        .sw_edge (w_sw_edge)
    );

    // Any number of simultaneous edges collapses into a single trigger.
    assign w_trig = |w_sw_edge;

    // ------------------------------------------------------------------
    // WARN blink phase
    // ------------------------------------------------------------------
`ifdef LAMP_WARN_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_HALF);

    localparam logic [BW-1:0] c_BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] c_BLINK_HALF = BW'(BLINK_HALF);

    logic [BW-1:0] r_blink;
    logic [BW-1:0] w_blink_nxt;

    assign w_blink_nxt = (r_blink == c_BLINK_LAST) ? '0 : r_blink + 1'b1;

    // Lit for the first BLINK_HALF counts of each period, dark for the rest.
    assign w_warn_f = (w_blink_nxt < c_BLINK_HALF);

    // Advances only on a WARN cycle that stays in WARN; every other cycle
    // forces it to 0, which also clears it ahead of each WARN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
        end else if ((r_state == WARN) && !w_trig && (r_timer != '0)) begin
            r_blink <= w_blink_nxt;
        end else begin
            r_blink <= '0;
        end
    end
`else
    // Solid lamp throughout WARN; BLINK_HALF is at least 1, so this is high.
    assign w_warn_f = (BLINK_HALF > 0);
`endif

    // ------------------------------------------------------------------
    // Lamp FSM and on-timer
    // ------------------------------------------------------------------
    // F is registered alongside the state so the lamp pin is glitch-free.
    // A trigger is checked before any state-specific behaviour, so it wins
    // over expiry and the lamp never goes dark on a coincident switch edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_f     <= 1'b0;
        end else if (w_trig) begin
            r_state <= ON;
            r_timer <= c_RELOAD;
            r_f     <= 1'b1;
        end else begin
            case (r_state)
                ON: begin
                    r_timer <= r_timer - 1'b1;
                    r_f     <= 1'b1;
                    // Leaving WARN_CYCLES means WARN_CYCLES-1 .. 0 remain.
                    if (r_timer == c_WARN_AT) begin
                        r_state <= WARN;
                    end
                end
                WARN: begin
                    if (r_timer == '0) begin
                        r_state <= IDLE;
                        r_f     <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        r_f     <= w_warn_f;
                    end
                end
                default: begin
                    // IDLE, plus recovery from the unused encoding.
                    r_state <= IDLE;
                    r_timer <= '0;
                    r_f     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign F          = r_f;
    assign lamp_state = r_state;
    assign remaining  = r_timer;
    assign sw_edge    = w_sw_edge;

endmodule : lamp_timer_ctrl
`default_nettype wire

// File: tb/tb_lamp_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lamp_timer_ctrl
//  Purpose  : Directed self-checking bench for lamp_timer_ctrl with
//             ON_CYCLES=20, WARN_CYCLES=6, BLINK_HALF=2, 20 ns clock.
//             Expected F in WARN follows LAMP_WARN_BLINK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lamp_timer_ctrl;

    localparam int N_SW        = 3;
    localparam int ON_CYCLES   = 20;
    localparam int WARN_CYCLES = 6;
    localparam int BLINK_HALF  = 2;
    localparam int W           = $clog2(ON_CYCLES);

    logic            clk;
    logic            r_rst;
    logic [N_SW-1:0] r_s;
    logic            w_f;
    logic [1:0]      w_lamp_state;
    logic [W-1:0]    w_remaining;
    logic [N_SW-1:0] w_sw_edge;

    int n_cmp;
    int n_err;

    lamp_timer_ctrl #(
        .N_SW        (N_SW),
        .ON_CYCLES   (ON_CYCLES),
        .WARN_CYCLES (WARN_CYCLES),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clk         (clk),
        .rst         (r_rst),
        .S           (r_s),
        .F           (w_f),
        .lamp_state  (w_lamp_state),
        .remaining   (w_remaining),
        .sw_edge     (w_sw_edge)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected state while lit, from the timer value alone.
    function automatic logic [1:0] exp_state(input int t);
        return (t >= WARN_CYCLES) ? 2'b01 : 2'b10;
    endfunction

    // Expected lamp while lit. WARN starts at timer WARN_CYCLES-1 with the
    // blink phase at 0, so the WARN pattern is 1,1,0,0,1,1 for these values.
    function automatic logic exp_f(input int t);
`ifdef LAMP_WARN_BLINK_EN
        if (t >= WARN_CYCLES) return 1'b1;
        return (((WARN_CYCLES - 1 - t) % (2 * BLINK_HALF)) < BLINK_HALF);
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk_lit(input string tag, input int t);
        chk($sformatf("%s remaining", tag), 32'(w_remaining), t);
        chk($sformatf("%s lamp_state", tag), 32'(w_lamp_state), 32'(exp_state(t)));
        chk($sformatf("%s F", tag), 32'(w_f), 32'(exp_f(t)));
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s idle lamp_state", tag), 32'(w_lamp_state), 0);
        chk($sformatf("%s idle F", tag), 32'(w_f), 0);
        chk($sformatf("%s idle remaining", tag), 32'(w_remaining), 0);
    endtask

    // Check the lit sequence for timer values from..to, stepping after each.
    task automatic run_lit(input string tag, input int from_t, input int to_t);
        for (int t = from_t; t >= to_t; t--) begin
            chk_lit($sformatf("%s t%0d", tag, t), t);
            step();
        end
    endtask

    // Light the lamp from IDLE with a one-cycle pulse; ends at remaining=19.
    task automatic start_from_idle(input string tag, input logic [N_SW-1:0] mask);
        r_s = mask;
        step();
        r_s = '0;
        chk($sformatf("%s edge+0 sw_edge", tag), 32'(w_sw_edge), 0);
        chk($sformatf("%s edge+0 F", tag), 32'(w_f), 0);
        step();
        chk($sformatf("%s edge+1 sw_edge", tag), 32'(w_sw_edge), 32'(mask));
        chk($sformatf("%s edge+1 F", tag), 32'(w_f), 0);
        step();
        chk($sformatf("%s edge+2 F", tag), 32'(w_f), 1);
        chk($sformatf("%s edge+2 sw_edge", tag), 32'(w_sw_edge), 0);
    endtask

    // Pulse while lit so the trigger reaches the FSM when remaining = t-2;
    // ends at the reloaded sample (remaining=19).
    task automatic pulse_lit(input string tag, input logic [N_SW-1:0] mask, input int t);
        chk_lit($sformatf("%s pre", tag), t);
        r_s = mask;
        step();
        r_s = '0;
        chk_lit($sformatf("%s sync", tag), t - 1);
        step();
        chk_lit($sformatf("%s trig", tag), t - 2);
        chk($sformatf("%s sw_edge", tag), 32'(w_sw_edge), 32'(mask));
        step();
        chk($sformatf("%s reload", tag), 32'(w_remaining), ON_CYCLES - 1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        r_rst = 1'b1;
        r_s   = '0;

        // Reset state
        repeat (3) step();
        chk_idle("reset");
        chk("reset sw_edge", 32'(w_sw_edge), 0);
        r_rst = 1'b0;
        repeat (2) step();
        chk_idle("post-reset");

        // 1: single pulse, full 14 ON + 6 WARN sequence, then dark
        start_from_idle("s1", 3'b001);
        run_lit("s1", ON_CYCLES - 1, 0);
        chk_idle("s1 expired");

        // 2: retrigger in ON, trigger arrives at remaining=10
        repeat (2) step();
        start_from_idle("s2", 3'b001);
        run_lit("s2", ON_CYCLES - 1, 13);
        pulse_lit("s2", 3'b010, 12);

        // 3: retrigger in WARN, trigger arrives at remaining=3
        run_lit("s3", ON_CYCLES - 1, 6);
        pulse_lit("s3", 3'b100, 5);

        // 4a: two switches in the same cycle give one reload
        run_lit("s4a", ON_CYCLES - 1, 13);
        pulse_lit("s4a", 3'b101, 12);

        // 4b: trigger on the remaining=0 cycle keeps the lamp lit
        run_lit("s4b", ON_CYCLES - 1, 3);
        pulse_lit("s4b", 3'b001, 2);
        chk("s4b state", 32'(w_lamp_state), 1);

        // 5: reset mid-WARN with a switch held high across release
        run_lit("s5", ON_CYCLES - 1, 4);
        chk("s5 in warn", 32'(w_lamp_state), 2);
        r_rst = 1'b1;
        r_s   = 3'b001;
        #1;
        chk("s5 async F", 32'(w_f), 0);
        chk("s5 async lamp_state", 32'(w_lamp_state), 0);
        chk("s5 async remaining", 32'(w_remaining), 0);
        repeat (2) step();
        r_rst = 1'b0;
        step();
        chk("s5 rel+1 sw_edge", 32'(w_sw_edge), 0);
        chk("s5 rel+1 F", 32'(w_f), 0);
        step();
        chk("s5 rel+2 sw_edge", 32'(w_sw_edge), 1);
        chk("s5 rel+2 F", 32'(w_f), 0);
        step();
        chk("s5 rel+3 F", 32'(w_f), 1);
        // Switch stays high: no further trigger, lamp times out normally.
        run_lit("s5 held", ON_CYCLES - 1, 0);
        chk_idle("s5 held expired");
        r_s = '0;
        repeat (3) step();
        chk_idle("s5 released");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lamp_timer_ctrl
`default_nettype wire
